text_line_engine: RTL
=====================

Name: text_line_engine

Overview:
- Parametrised successor of the terminal text-buffer editor.
- Sits between the escape-sequence parser and the line-wide text RAM; one line is one RAM word.
- Executes one decoded edit command at a time over a valid/ready handshake: range fill, character delete, character insert (new), region scroll up/down with a configurable region, and row erase.
- Generalised in columns, rows, character width and RAM read latency.

Parameters:
- COLS, 80, characters per line; RAM word width is COLS*CHAR_W.
- ROWS, 30, lines in the buffer.
- CHAR_W, 32, bits per character cell (attribute + code).
- RD_LAT, 2, RAM read latency in cycles from address presented to ram_rdata valid; legal range 1..4.
- BLANK, 32'h0007fc20, cell value written by erase, delete tail fill, insert gaps and scroll vacated rows.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, engine idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_op, input, 3, 0 SET, 1 DEL, 2 INS, 3 SCROLL_UP, 4 SCROLL_DN, 5 ERASE_ROWS, 6–7 reserved.
- cmd_row, input, 8, target row for SET, DEL and INS.
- cmd_a, input, 8, start column (SET/DEL/INS) or top row (SCROLL/ERASE).
- cmd_b, input, 8, end column (SET) or bottom row (SCROLL/ERASE); the range includes both ends.
- cmd_count, input, 8, cells (DEL/INS) or lines (SCROLL); a value of 0 is treated as 1.
- cmd_data, input, CHAR_W, fill cell for SET.
- ram_addr, output, 8, RAM line address.
- ram_wren, output, 1, write strobe, one cycle per line written.
- ram_wdata, output, COLS*CHAR_W, line to write; cell i is at bits [CHAR_W*i +: CHAR_W].
- ram_rdata, input, COLS*CHAR_W, read line.
- busy, output, 1, equal to !cmd_ready.
- done, output, 1, one-cycle pulse when a command retires.
- err, output, 1, one-cycle pulse coincident with done for a rejected command.

Behaviour:
- Reset values: ram_wren 0, ram_addr 0, ram_wdata 0, done 0, err 0, cmd_ready 1, state IDLE.
- Reset mid-operation: the engine drops the command, returns to IDLE and deasserts ram_wren asynchronously; no partial-line write completes after rst rises.
- Command capture: all cmd_* fields are registered on accept; input changes afterwards have no effect.
- States: IDLE, L_RD, L_WAIT, L_MOD, L_WR, S_RD, S_WAIT, S_WR, E_WR, FIN.
- Line ops (SET, DEL, INS), accepted at cycle T:
  - T+1: L_RD drives ram_addr=row, wren=0.
  - L_WAIT lasts RD_LAT-1 cycles.
  - T+1+RD_LAT: L_MOD registers the new line.
  - T+2+RD_LAT: L_WR drives wren=1 with the same address.
  - T+3+RD_LAT: FIN pulses done; cmd_ready rises the same cycle.
  - With RD_LAT=2, the write is at T+4 and done at T+5.
- SET: cells a..b are replaced with cmd_data; all others are unchanged.
- DEL: for i>=a, cell i takes old cell i+n; cells that source at or beyond COLS take BLANK; cells below a are unchanged.
- INS: for i>=a+n, cell i takes old cell i-n; cells a..a+n-1 take BLANK; cells shifted past COLS-1 are discarded; cells below a are unchanged.
- Column clamp: b >= COLS is clamped to COLS-1.
- a > b for SET, or a >= COLS for DEL/INS: no RAM write, done without err.
- n >= COLS-a: the whole tail from a takes BLANK.
- Region ops: top=a, bottom=b, n=count.
  - Rejected with err when top > bottom, bottom >= ROWS, or cmd_row >= ROWS on a line op. No RAM activity occurs; done and err pulse at T+1.
  - Reserved cmd_op values are rejected the same way.
- SCROLL_UP: for r = top .. bottom-n ascending, S_RD reads r+n, S_WAIT lasts RD_LAT-1 cycles, and S_WR writes ram_rdata to r. Rows bottom-n+1..bottom are then written BLANK in E_WR, one per cycle.
- SCROLL_DN: for r = bottom down to top+n, read r-n and write r. Rows top..top+n-1 are then written BLANK.
- Scroll with n >= bottom-top+1: no copies; the whole region is erased.
- Rows outside [top,bottom] are never written.
- ERASE_ROWS: rows top..bottom are written BLANK, one per cycle, then FIN.
- Cycle cost: each copied line costs RD_LAT+1 cycles, and each erased row costs 1 cycle.
- Arithmetic: row and column arithmetic uses 9-bit intermediates, so top+n and a+n never wrap.
- Line shifts are a combinational per-cell mux driven by registered a, n and mode, and are registered in L_MOD.

Test Plan:
- Overrides: COLS=8, ROWS=6, CHAR_W=8, RD_LAT=2, BLANK=8'h20. Row 2 preloaded with "ABCDEFGH".
- SET row=2, a=3, b=5, data='x' -> wren exactly at T+4 to addr 2, row becomes "ABCxxxGH"; done at T+5.
- DEL row=2, a=2, count=3 -> "ABFGH   ". A second DEL with count=0 on fresh "ABCDEFGH" at a=7 -> "ABCDEFG ".
- INS row=2, a=1, count=2 -> "A  BCDEF". INS with a=6, count=9 -> "ABCDEF  ".
- SCROLL_UP top=1, bottom=4, count=1, rows loaded with their index -> rows become 0,2,3,4,BLANK,5. Row 0 and row 5 see no writes. The reverse check is SCROLL_DN with the same arguments -> 0,BLANK,1,2,3,5.
- Errors: SCROLL_UP top=4, bottom=2 -> done and err pulse at T+1 with no wren. cmd_op=7 -> same. SET with a=6, b=3 -> done, no err, no write.
- Reset and handshake: assert rst during S_WAIT of a scroll -> wren low immediately, cmd_ready=1 after release, and the next SET executes normally. cmd_valid held high while busy is accepted only after FIN.

Source files
------------

// File: rtl/text_line_engine_if.sv
// Command and line-RAM bus between the escape parser, the line engine and the text RAM.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready handshake; the RAM side is never stalled.
interface text_line_engine_if #(
  parameter int COLS   = 80,
  parameter int CHAR_W = 32
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [2:0]               cmd_op;
  logic [7:0]               cmd_row;
  logic [7:0]               cmd_a;
  logic [7:0]               cmd_b;
  logic [7:0]               cmd_count;
  logic [CHAR_W-1:0]        cmd_data;
  logic [7:0]               ram_addr;
  logic                     ram_wren;
  logic [COLS*CHAR_W-1:0]   ram_wdata;
  logic [COLS*CHAR_W-1:0]   ram_rdata;
  logic                     busy;
  logic                     done;
  logic                     err;

  // Engine side: consumes commands and read data, drives the RAM and status.
  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_a, cmd_b, cmd_count, cmd_data, ram_rdata,
    output cmd_ready, ram_addr, ram_wren, ram_wdata, busy, done, err
  );

  // Parser/RAM side: issues commands and returns read data.
  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_a, cmd_b, cmd_count, cmd_data, ram_rdata,
    input  cmd_ready, ram_addr, ram_wren, ram_wdata, busy, done, err
  );
endinterface

// File: rtl/text_line_engine.sv
// Executes one edit command (fill, delete, insert, scroll, erase) on a line-per-word text RAM.
// Latency: line ops write at T+2+RD_LAT, done at T+3+RD_LAT; rejects/no-ops done at T+1.
// Backpressure: cmd_ready only in IDLE/FIN; a held command is taken on the FIN cycle.
module text_line_engine #(
  parameter int                COLS   = 80,
  parameter int                ROWS   = 30,
  parameter int                CHAR_W = 32,
  parameter int                RD_LAT = 2,
  parameter logic [CHAR_W-1:0] BLANK  = CHAR_W'(32'h0007fc20)
) (
  input logic               clk,
  input logic               rst,
  text_line_engine_if.slave bus
);
  localparam int W = COLS * CHAR_W;

  localparam logic [2:0] OP_SET = 3'd0;
  localparam logic [2:0] OP_DEL = 3'd1;
  localparam logic [2:0] OP_INS = 3'd2;
  localparam logic [2:0] OP_SUP = 3'd3;
  localparam logic [2:0] OP_SDN = 3'd4;
  localparam logic [2:0] OP_ERS = 3'd5;

  typedef enum logic [3:0] {
    IDLE, L_RD, L_WAIT, L_MOD, L_WR, S_RD, S_WAIT, S_WR, E_WR, FIN
  } state_e;

  state_e state, state_n, c_first;

  // Captured command and walking pointers
  logic [2:0]        op_q;
  logic [7:0]        row_q;
  logic [8:0]        a_q, b_q, n_q;
  logic [CHAR_W-1:0] data_q;
  logic              err_q, up_q;
  logic [8:0]        r_q, cnt_q, e_q, ee_q;
  logic [1:0]        wcnt;
  logic [W-1:0]      line_q;

  // Accept-time decode, 9-bit so a+n and top+n never wrap
  logic [8:0] c_a, c_b, c_row, c_n, c_span, c_nc, c_copies, c_bcl;
  logic       c_line, c_region, c_reject, c_noop;

  logic [8:0]   src;
  logic [31:0]  a_w, b_w, n_w, sh;
  logic [W-1:0] del_sh, ins_sh, mod_line, blank_line;
  logic         accept;

  assign blank_line = {COLS{BLANK}};
  assign accept     = bus.cmd_valid && bus.cmd_ready;
  assign src        = up_q ? (r_q + n_q) : (r_q - n_q);

  // Classify the offered command and pick the first state it will run in
  always_comb begin
    c_a      = {1'b0, bus.cmd_a};
    c_b      = {1'b0, bus.cmd_b};
    c_row    = {1'b0, bus.cmd_row};
    c_n      = (bus.cmd_count == 8'd0) ? 9'd1 : {1'b0, bus.cmd_count};
    c_span   = c_b - c_a + 9'd1;
    c_nc     = (c_n > c_span) ? c_span : c_n;
    c_copies = c_span - c_nc;
    c_bcl    = (c_b >= 9'(COLS)) ? 9'(COLS - 1) : c_b;
    c_line   = (bus.cmd_op <= OP_INS);
    c_region = (bus.cmd_op == OP_SUP) || (bus.cmd_op == OP_SDN) || (bus.cmd_op == OP_ERS);
    c_reject = !(c_line || c_region)
             || (c_line && (c_row >= 9'(ROWS)))
             || (c_region && ((c_a > c_b) || (c_b >= 9'(ROWS))));
    c_noop   = (bus.cmd_op == OP_SET) ? (c_a > c_bcl) : (c_a >= 9'(COLS));
    if (c_reject)                                          c_first = FIN;
    else if (c_line)                                       c_first = c_noop ? FIN : L_RD;
    else if ((bus.cmd_op == OP_ERS) || (c_copies == 9'd0)) c_first = E_WR;
    else                                                   c_first = S_RD;
  end

  // Per-cell line rewrite from the registered column, count and opcode
  assign a_w    = 32'(a_q);
  assign b_w    = 32'(b_q);
  assign n_w    = 32'(n_q);
  assign sh     = n_w * 32'(CHAR_W);
  assign del_sh = bus.ram_rdata >> sh;
  assign ins_sh = bus.ram_rdata << sh;

  always_comb begin
    mod_line = bus.ram_rdata;
    for (int i = 0; i < COLS; i++) begin
      if (32'(i) >= a_w) begin
        case (op_q)
          OP_SET: if (32'(i) <= b_w) mod_line[CHAR_W*i +: CHAR_W] = data_q;
          OP_DEL: mod_line[CHAR_W*i +: CHAR_W] =
                    ((32'(i) + n_w) < 32'(COLS)) ? del_sh[CHAR_W*i +: CHAR_W] : BLANK;
          OP_INS: mod_line[CHAR_W*i +: CHAR_W] =
                    (32'(i) < (a_w + n_w)) ? BLANK : ins_sh[CHAR_W*i +: CHAR_W];
          default: ;
        endcase
      end
    end
  end

  // State register; reset drops any command in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and RAM strobes, decoded straight from the state so rst kills wren at once
  always_comb begin
    state_n       = state;
    bus.ram_addr  = 8'd0;
    bus.ram_wren  = 1'b0;
    bus.ram_wdata = '0;
    case (state)
      IDLE, FIN: state_n = bus.cmd_valid ? c_first : IDLE;
      L_RD: begin
        bus.ram_addr = row_q;
        state_n      = (RD_LAT == 1) ? L_MOD : L_WAIT;
      end
      L_WAIT: begin
        bus.ram_addr = row_q;
        if (32'(wcnt) == RD_LAT - 2) state_n = L_MOD;
      end
      L_MOD: begin
        bus.ram_addr = row_q;
        state_n      = L_WR;
      end
      L_WR: begin
        bus.ram_addr  = row_q;
        bus.ram_wren  = 1'b1;
        bus.ram_wdata = line_q;
        state_n       = FIN;
      end
      S_RD: begin
        bus.ram_addr = 8'(src);
        state_n      = (RD_LAT == 1) ? S_WR : S_WAIT;
      end
      S_WAIT: begin
        bus.ram_addr = 8'(src);
        if (32'(wcnt) == RD_LAT - 2) state_n = S_WR;
      end
      S_WR: begin
        bus.ram_addr  = 8'(r_q);
        bus.ram_wren  = 1'b1;
        bus.ram_wdata = bus.ram_rdata;
        state_n       = (cnt_q == 9'd1) ? E_WR : S_RD;
      end
      E_WR: begin
        bus.ram_addr  = 8'(e_q);
        bus.ram_wren  = 1'b1;
        bus.ram_wdata = blank_line;
        state_n       = (e_q == ee_q) ? FIN : E_WR;
      end
      default: state_n = IDLE;
    endcase
  end

  // Command capture, wait counting, line register and row pointer walking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 3'd0;
      row_q  <= 8'd0;
      a_q    <= 9'd0;
      b_q    <= 9'd0;
      n_q    <= 9'd0;
      data_q <= '0;
      err_q  <= 1'b0;
      up_q   <= 1'b0;
      r_q    <= 9'd0;
      cnt_q  <= 9'd0;
      e_q    <= 9'd0;
      ee_q   <= 9'd0;
      wcnt   <= 2'd0;
      line_q <= '0;
    end else begin
      case (state)
        IDLE, FIN: if (accept) begin
          op_q   <= bus.cmd_op;
          row_q  <= bus.cmd_row;
          a_q    <= c_a;
          b_q    <= c_bcl;
          n_q    <= c_n;
          data_q <= bus.cmd_data;
          err_q  <= c_reject;
          up_q   <= (bus.cmd_op == OP_SUP);
          cnt_q  <= c_copies;
          r_q    <= (bus.cmd_op == OP_SUP) ? c_a : c_b;
          case (bus.cmd_op)
            OP_SUP: begin
              e_q  <= c_b - c_nc + 9'd1;
              ee_q <= c_b;
            end
            OP_SDN: begin
              e_q  <= c_a;
              ee_q <= c_a + c_nc - 9'd1;
            end
            default: begin
              e_q  <= c_a;
              ee_q <= c_b;
            end
          endcase
        end
        L_RD, S_RD:     wcnt <= 2'd0;
        L_WAIT, S_WAIT: wcnt <= wcnt + 2'd1;
        L_MOD:          line_q <= mod_line;
        S_WR: begin
          r_q   <= up_q ? (r_q + 9'd1) : (r_q - 9'd1);
          cnt_q <= cnt_q - 9'd1;
        end
        E_WR:           e_q <= e_q + 9'd1;
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE) || (state == FIN);
  assign bus.busy      = !bus.cmd_ready;
  assign bus.done      = (state == FIN);
  assign bus.err       = (state == FIN) && err_q;
endmodule
